// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes and datapath select codes.
package mips_multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_HALT   = 4'd15
   } state_e;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_4    = 2'b01;
   localparam logic [1:0] SRCB_SEXT = 2'b10;
   localparam logic [1:0] SRCB_SHL2 = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: decodes datapath controls from the state register,
// handshakes with shared memory, counts retired instructions and flags unknown opcodes.
module mips_multicycle_ctrl
   import mips_multicycle_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             res,
   input  logic             run,
   input  logic [5:0]       op,
   input  logic             zero,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_src,
   output logic             pc_en,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_cnt
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q;
   logic             retire;

   always_ff @(posedge clk) begin
      if (res) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (retire)
            cnt_q <= cnt_d;
         if (state_d == S_HALT)
            illegal_q <= 1'b1;
      end
   end

   assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:  if (run && mem_ack) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_HALT;
            endcase
         end
         S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ack) state_d = S_MEMWB;
         S_MEMWR: begin
            if (mem_ack) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_HALT;
      endcase
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_op     = ALU_ADD;
      pc_src     = PC_ALU;
      pc_en      = 1'b0;
      case (state_q)
         S_FETCH: begin
            // A held front panel keeps the bus idle; selects stay at zero too.
            if (run) begin
               mem_req   = 1'b1;
               alu_src_b = SRCB_4;
               ir_write  = mem_ack;
               pc_en     = mem_ack;
            end
         end
         S_DECODE: alu_src_b = SRCB_SHL2;
         S_MEMADR, S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_SEXT;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = PC_ALUOUT;
            pc_en     = zero;
         end
         S_ADDIWB: reg_write = 1'b1;
         S_JUMP: begin
            pc_src = PC_JUMP;
            pc_en  = 1'b1;
         end
         default: ;
      endcase
   end

   assign illegal   = illegal_q;
   assign state     = state_q;
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: per-instruction cycle plans checked against a state/output table.
module tb_mips_multicycle_ctrl;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             res = 1'b1;
   logic             run = 1'b0;
   logic [5:0]       op = 6'd0;
   logic             zero = 1'b0;
   logic             mem_ack = 1'b0;
   logic             mem_req, mem_we, iord, ir_write, reg_write, reg_dst, mem_to_reg;
   logic             alu_src_a, pc_en, illegal;
   logic [1:0]       alu_src_b, alu_op, pc_src;
   logic [3:0]       state;
   logic [CNT_W-1:0] instr_cnt;

   int               n_chk = 0;
   int               n_fail = 0;
   logic [CNT_W-1:0] cnt_m = '0;
   logic [15:0]      obs;

   mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .res(res), .run(run), .op(op), .zero(zero), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_src(pc_src), .pc_en(pc_en), .illegal(illegal), .state(state),
      .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   // {mem_req,mem_we,iord,ir_write,reg_write,reg_dst,mem_to_reg,alu_src_a,src_b[2],alu_op[2],pc_src[2],pc_en,illegal}
   assign obs = {mem_req, mem_we, iord, ir_write, reg_write, reg_dst, mem_to_reg,
                 alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_out(input int st, input logic rn, input logic ak, input logic z);
      case (st)
         0:  return rn ? (ak ? 16'h9042 : 16'h8040) : 16'h0000;
         1:  return 16'h00C0;
         2:  return 16'h0180;
         3:  return 16'hA000;
         4:  return 16'h0A00;
         5:  return 16'hE000;
         6:  return 16'h0120;
         7:  return 16'h0C00;
         8:  return z ? 16'h0116 : 16'h0114;
         9:  return 16'h0180;
         10: return 16'h0800;
         11: return 16'h000A;
         15: return 16'h0001;
         default: return 16'hFFFF;
      endcase
   endfunction

   task automatic cyc(input logic r, input logic rn, input logic ak, input logic [5:0] o,
                      input logic z, input int st);
      @(posedge clk);
      #1;
      res = r; run = rn; mem_ack = ak; op = o; zero = z;
      @(negedge clk);
      check("state", {28'd0, state}, st);
      check("outputs", {16'd0, obs}, {16'd0, exp_out(st, rn, ak, z)});
      check("instr_cnt", {{(32-CNT_W){1'b0}}, instr_cnt}, {{(32-CNT_W){1'b0}}, cnt_m});
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Plays one instruction from idle FETCH through its last state; returns after DECODE for unknown opcodes.
   task automatic run_instr(input logic [5:0] o, input int idle, input int wf, input int wm, input logic zb);
      for (int i = 0; i < idle; i++) cyc(0, 0, rb(), 6'($urandom), rb(), 0);
      for (int i = 0; i < wf; i++)   cyc(0, 1, 0, 6'($urandom), rb(), 0);
      cyc(0, 1, 1, 6'($urandom), rb(), 0);
      cyc(0, rb(), rb(), o, rb(), 1);
      case (o)
         6'b100011: begin
            cyc(0, rb(), rb(), o, rb(), 2);
            for (int i = 0; i < wm; i++) cyc(0, rb(), 0, o, rb(), 3);
            cyc(0, rb(), 1, o, rb(), 3);
            cyc(0, rb(), rb(), o, rb(), 4);
         end
         6'b101011: begin
            cyc(0, rb(), rb(), o, rb(), 2);
            for (int i = 0; i < wm; i++) cyc(0, rb(), 0, o, rb(), 5);
            cyc(0, rb(), 1, o, rb(), 5);
         end
         6'b000000: begin
            cyc(0, rb(), rb(), o, rb(), 6);
            cyc(0, rb(), rb(), o, rb(), 7);
         end
         6'b000100: cyc(0, rb(), rb(), o, zb, 8);
         6'b001000: begin
            cyc(0, rb(), rb(), o, rb(), 9);
            cyc(0, rb(), rb(), o, rb(), 10);
         end
         6'b000010: cyc(0, rb(), rb(), o, rb(), 11);
         default: return;
      endcase
      cnt_m = cnt_m + 1'b1;
   endtask

   initial begin
      logic [5:0] ops [6];
      ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
      ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;

      // Two reset cycles; the second also checks the post-reset FETCH outputs.
      @(posedge clk); #1; res = 1'b1; run = 1'b1; mem_ack = 1'b0;
      cyc(1, 1, 0, 6'd0, 0, 0);

      // R-type with immediate acks: 0,1,6,7 then back to 0 with one retire.
      run_instr(6'b000000, 0, 0, 0, 0);
      cyc(0, 0, 0, 6'd0, 0, 0);

      // LW with two wait cycles in MEMRD.
      run_instr(6'b100011, 0, 0, 2, 0);

      // BEQ taken then not taken.
      run_instr(6'b000100, 0, 0, 0, 1);
      run_instr(6'b000100, 0, 0, 0, 0);

      // J, then front panel holds FETCH before resuming.
      run_instr(6'b000010, 0, 0, 0, 0);
      run_instr(6'b001000, 4, 0, 0, 0);

      for (int n = 0; n < 150; n++)
         run_instr(ops[$urandom_range(0, 5)],
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                   $urandom_range(0, 2), $urandom_range(0, 3), rb());

      // Drive the counter to all-ones, then one more retire must wrap to zero.
      while (cnt_m != {CNT_W{1'b1}}) run_instr(6'b000010, 0, 0, 0, rb());
      run_instr(6'b000000, 0, 0, 0, 0);
      cyc(0, 0, 0, 6'd0, 0, 0);

      // Reset in the middle of a stalled SW: FETCH next cycle, no write strobe after.
      cyc(0, 1, 1, 6'd0, 0, 0);
      cyc(0, 1, 0, 6'b101011, 0, 1);
      cyc(0, 1, 0, 6'b101011, 0, 2);
      cyc(0, 1, 0, 6'b101011, 0, 5);
      cyc(0, 1, 0, 6'b101011, 0, 5);
      cyc(1, 0, 0, 6'b101011, 0, 5);
      cnt_m = '0;
      for (int i = 0; i < 3; i++) cyc(0, 0, rb(), 6'b101011, rb(), 0);

      // Reset wins over a completing memory read.
      run_instr(6'b001000, 0, 1, 0, 0);
      cyc(0, 1, 1, 6'd0, 0, 0);
      cyc(0, 1, 0, 6'b100011, 0, 1);
      cyc(0, 1, 0, 6'b100011, 0, 2);
      cyc(1, 1, 1, 6'b100011, 0, 3);
      cnt_m = '0;
      cyc(0, 0, 0, 6'd0, 0, 0);

      // Unknown opcode halts with the sticky flag and ignores every input.
      run_instr(6'b111111, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(0, rb(), rb(), 6'($urandom), rb(), 15);
      cyc(1, 1, 1, 6'd0, 0, 15);
      cnt_m = '0;
      cyc(0, 1, 0, 6'd0, 0, 0);
      run_instr(6'b000010, 0, 0, 0, 0);
      cyc(0, 0, 0, 6'd0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
